// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, opcodes, queue entry type and static predictor
package fetch_queue_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [6:0] {
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6f
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pred_pc;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  // JAL targets are known from the word alone; everything else falls through.
  function automatic logic [DATA_WIDTH-1:0] predict_next_pc(
    input logic [DATA_WIDTH-1:0] inst,
    input logic [DATA_WIDTH-1:0] pc
  );
    logic [DATA_WIDTH-1:0] imm;
    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (inst[6:0] == OPC_JAL) begin
      return pc + imm;
    end
    return pc + DATA_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - circular instruction buffer with push, pop and flush
module fetch_queue_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 96
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full      = (r_count == FULL_COUNT);
  assign o_empty     = (r_count == '0);
  assign o_head_data = r_mem[r_head];
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;

  // Flush only rewinds the pointers; stale entries stay visible at the head.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_en) begin
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) begin
          r_mem[r_tail] <= i_push_data;
          r_tail        <= r_tail + 1'b1;
        end
        if (w_do_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC generation, single-outstanding memory fetch and instruction queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IQ_DEPTH  = 8,
  parameter int IQ_ADDR_W = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  mem_req_valid,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  iq_out_valid,
  output logic [DATA_WIDTH-1:0] iq_out_inst,
  output logic [DATA_WIDTH-1:0] iq_out_pc,
  output logic [DATA_WIDTH-1:0] iq_out_pred_pc,
  input  logic                  iq_out_ready
);

  fetch_state_e          r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_req;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_pred;
  iq_entry_t             w_push_entry;
  iq_entry_t             w_head_entry;
  logic [IQ_ENTRY_W-1:0] w_head_bits;

  // The request is decoded from state so it can go out the cycle the FSM re-enters IDLE.
  assign w_req = !rst_in && rdy_in && !redirect_valid && (r_state == ST_IDLE) && !w_full;
  assign w_pred = predict_next_pc(mem_resp_data, r_fetch_pc);
  assign w_push = (r_state == ST_WAIT) && mem_resp_valid && !redirect_valid;
  assign w_pop  = !w_empty && iq_out_ready;

  assign w_push_entry = {mem_resp_data, r_fetch_pc, w_pred};
  assign w_head_entry = w_head_bits;

  assign mem_req_valid  = w_req;
  assign mem_req_addr   = r_fetch_pc;
  assign iq_out_valid   = !w_empty;
  assign iq_out_inst    = w_head_entry.inst;
  assign iq_out_pc      = w_head_entry.pc;
  assign iq_out_pred_pc = w_head_entry.pred_pc;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= '0;
    end else if (rdy_in) begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        case (r_state)
          ST_WAIT: r_state <= mem_resp_valid ? ST_IDLE : ST_DROP;
          ST_DROP: r_state <= mem_resp_valid ? ST_IDLE : ST_DROP;
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_req) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (mem_resp_valid) begin
              r_fetch_pc <= w_pred;
              r_state    <= ST_IDLE;
            end
          end
          ST_DROP: begin
            if (mem_resp_valid) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  fetch_queue_fifo #(
    .DEPTH (IQ_DEPTH),
    .ADDR_W(IQ_ADDR_W),
    .WIDTH (IQ_ENTRY_W)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_en       (rdy_in),
    .i_flush    (redirect_valid),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_head_data(w_head_bits),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized bench with a transaction-level fetch model
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_out_valid;
  logic [31:0] iq_out_inst;
  logic [31:0] iq_out_pc;
  logic [31:0] iq_out_pred_pc;
  logic        iq_out_ready;

  fetch_queue #(.IQ_DEPTH(8), .IQ_ADDR_W(3)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .iq_out_valid  (iq_out_valid),
    .iq_out_inst   (iq_out_inst),
    .iq_out_pc     (iq_out_pc),
    .iq_out_pred_pc(iq_out_pred_pc),
    .iq_out_ready  (iq_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_count = 0;
  logic [31:0] prog [256];
  ent_t        mq[$];
  ent_t        pop_log[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_drop;
  logic        m_pend;
  logic [31:0] m_addr;
  int          m_delay;
  int          lat_lo;
  int          lat_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pred(input logic [31:0] inst, input logic [31:0] pc);
    logic [20:0] off;
    if (inst[6:0] != 7'h6f) return pc + 32'd4;
    off = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return pc + 32'($signed(off));
  endfunction

  function automatic logic [31:0] jal_enc(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
  endfunction

  function automatic logic [31:0] get_req(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] get_pop_pc(input int i);
    if (i < pop_log.size()) return pop_log[i].pc;
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] find_pred(input logic [31:0] pc);
    foreach (pop_log[i]) if (pop_log[i].pc == pc) return pop_log[i].pred;
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] req_after(input logic [31:0] addr);
    for (int i = 0; i + 1 < req_log.size(); i++) if (req_log[i] == addr) return req_log[i+1];
    return 32'hdead_beef;
  endfunction

  // One clock: drive memory, check DUT against the model, advance the model, cross the edge.
  task automatic do_cycle();
    logic resp;
    logic exp_req;
    logic [31:0] req_addr;
    ent_t e;
    resp = rdy && m_pend && (m_delay == 0);
    mem_resp_valid = resp;
    mem_resp_data  = prog[m_addr[9:2]];
    #1;
    exp_req  = !rst && rdy && !redirect_valid && !m_out && (mq.size() < 8);
    req_addr = m_pc;
    if (mem_req_valid === 1'b1) begin
      req_count++;
      req_log.push_back(mem_req_addr);
      req_cyc.push_back(cyc);
    end
    if (!rst) begin
      check("req_valid", 32'(mem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", mem_req_addr, m_pc);
      check("out_valid", 32'(iq_out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_inst", iq_out_inst, mq[0].inst);
        check("out_pc", iq_out_pc, mq[0].pc);
        check("out_pred", iq_out_pred_pc, mq[0].pred);
      end
    end
    if (rst) begin
      mq.delete();
      m_pc = '0; m_out = 0; m_drop = 0; m_pend = 0; m_addr = '0; m_delay = 0;
    end else if (rdy) begin
      if (resp) m_pend = 0;
      else if (m_pend) m_delay--;
      if (exp_req) begin
        m_pend = 1; m_addr = req_addr; m_delay = $urandom_range(lat_lo, lat_hi);
      end
      if (redirect_valid) begin
        if (m_out && !resp) m_drop = 1;
        else begin m_out = 0; m_drop = 0; end
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        if (iq_out_ready && mq.size() != 0) begin
          pop_log.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (resp && m_out) begin
          if (m_drop) m_drop = 0;
          else begin
            e.inst = mem_resp_data; e.pc = m_pc; e.pred = model_pred(mem_resp_data, m_pc);
            mq.push_back(e);
            m_pc = e.pred;
          end
          m_out = 0;
        end
        if (exp_req) m_out = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic clear_logs();
    pop_log.delete(); req_log.delete(); req_cyc.delete(); req_count = 0;
  endtask

  task automatic reset_dut(input string tag);
    rst = 1; rdy = 1; redirect_valid = 0;
    do_cycle(); do_cycle();
    check({tag, "_rst_req"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_rst_addr"}, mem_req_addr, 32'd0);
    check({tag, "_rst_valid"}, 32'(iq_out_valid), 32'd0);
    check({tag, "_rst_inst"}, iq_out_inst, 32'd0);
    check({tag, "_rst_pc"}, iq_out_pc, 32'd0);
    check({tag, "_rst_pred"}, iq_out_pred_pc, 32'd0);
    rst = 0;
    clear_logs();
  endtask

  task automatic fill_addi();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;
  endtask

  // Advance until a request is outstanding and its response is not arriving this cycle.
  task automatic wait_mid_wait(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && !(m_pend && m_delay == 0)) found = 1;
      else do_cycle();
    end
    check({tag, "_setup"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] s_addr, s_inst, s_pc, s_pred;
    logic        s_valid;
    int          c0;
    int          rc;
    bit          found;
    logic [20:0] imm;
    logic [31:0] w;

    rst = 1; rdy = 1; redirect_valid = 0; redirect_pc = '0; iq_out_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
    m_pc = '0; m_out = 0; m_drop = 0; m_pend = 0; m_addr = '0; m_delay = 0;
    lat_lo = 0; lat_hi = 0;
    fill_addi();
    @(negedge clk);

    // Straight-line ADDI stream at one-cycle latency.
    iq_out_ready = 1;
    reset_dut("p1");
    c0 = cyc;
    run(12);
    check("p1_first_req_cycle", 32'(req_cyc.size() > 0 ? req_cyc[0] : -1), 32'(c0));
    check("p1_req0", get_req(0), 32'h0);
    check("p1_req1", get_req(1), 32'h4);
    check("p1_req2", get_req(2), 32'h8);
    check("p1_req_spacing", 32'(req_cyc.size() > 1 ? req_cyc[1] - req_cyc[0] : -1), 32'd2);
    check("p1_pop_pc0", get_pop_pc(0), 32'h0);
    check("p1_pop_pc1", get_pop_pc(1), 32'h4);
    check("p1_pop_pc2", get_pop_pc(2), 32'h8);
    check("p1_pred_of_8", find_pred(32'h8), 32'hc);

    // JAL forward +0x20 at 0x10, JAL backward -8 at 0x40.
    prog[32'h10 >> 2] = 32'h0200_006f;
    prog[32'h40 >> 2] = 32'hff9f_f06f;
    reset_dut("p2");
    run(40);
    check("p2_jal_fwd_pred", find_pred(32'h10), 32'h30);
    check("p2_req_after_jal", req_after(32'h10), 32'h30);
    check("p2_jal_back_pred", find_pred(32'h40), 32'h38);
    check("p2_req_after_back", req_after(32'h40), 32'h38);
    fill_addi();

    // Consumer stalled: queue fills to eight and requests stop.
    iq_out_ready = 0;
    reset_dut("p3");
    run(40);
    check("p3_req_count_full", 32'(req_count), 32'd8);
    check("p3_valid_full", 32'(iq_out_valid), 32'd1);
    iq_out_ready = 1;
    do_cycle();
    iq_out_ready = 0;
    rc = req_count;
    do_cycle();
    check("p3_req_after_pop", 32'(req_count - rc), 32'd1);
    run(8);
    check("p3_refull_no_req", 32'(req_count - rc), 32'd1);

    // Redirect while a fetch is in flight.
    iq_out_ready = 1;
    lat_lo = 2; lat_hi = 2;
    reset_dut("p4");
    run(5);
    wait_mid_wait("p4");
    clear_logs();
    redirect_valid = 1; redirect_pc = 32'h100;
    do_cycle();
    redirect_valid = 0;
    check("p4_empty_after_redirect", 32'(iq_out_valid), 32'd0);
    run(20);
    check("p4_first_req", get_req(0), 32'h100);
    check("p4_first_pop_pc", get_pop_pc(0), 32'h100);
    check("p4_second_pop_pc", get_pop_pc(1), 32'h104);

    // Redirect in the same cycle as a push and a pop.
    lat_lo = 0; lat_hi = 0;
    iq_out_ready = 0;
    reset_dut("p5");
    run(8);
    iq_out_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_pend && m_delay == 0 && mq.size() != 0) found = 1;
      else do_cycle();
    end
    check("p5_setup", 32'(found), 32'd1);
    clear_logs();
    redirect_valid = 1; redirect_pc = 32'h200;
    do_cycle();
    redirect_valid = 0;
    check("p5_valid_after", 32'(iq_out_valid), 32'd0);
    run(12);
    check("p5_no_stale_pop", get_pop_pc(0), 32'h200);
    check("p5_first_req", get_req(0), 32'h200);

    // Global stall for three cycles in the middle of a fetch.
    lat_lo = 2; lat_hi = 2;
    iq_out_ready = 1;
    reset_dut("p6");
    run(7);
    wait_mid_wait("p6");
    s_addr = mem_req_addr; s_valid = iq_out_valid; s_inst = iq_out_inst;
    s_pc = iq_out_pc; s_pred = iq_out_pred_pc;
    rc = req_count;
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      check("p6_hold_addr", mem_req_addr, s_addr);
      check("p6_hold_valid", 32'(iq_out_valid), 32'(s_valid));
      check("p6_hold_inst", iq_out_inst, s_inst);
      check("p6_hold_pc", iq_out_pc, s_pc);
      check("p6_hold_pred", iq_out_pred_pc, s_pred);
    end
    check("p6_no_req_stalled", 32'(req_count - rc), 32'd0);
    rdy = 1;
    run(20);

    // Random program, latency, back-pressure, stalls and redirects.
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        imm = 21'($urandom_range(0, 255)) << 1;
        if ($urandom_range(0, 1) == 1) imm = -imm;
        prog[i] = jal_enc(imm);
      end else begin
        w = $urandom;
        if (w[6:0] == 7'h6f) w[0] = 1'b0;
        prog[i] = w;
      end
    end
    lat_lo = 0; lat_hi = 3;
    reset_dut("p7");
    for (int i = 0; i < 700; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      iq_out_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom & 32'h0000_03fc;
      do_cycle();
    end
    rdy = 1; redirect_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch unit with an instruction queue, directly upstream of the combinational decoder. It generates the fetch PC and issues one word-read request at a time to the memory controller. Each returned instruction is buffered with its PC and a statically predicted next PC, and the queue head is presented to the decode stage under a valid/ready handshake. A redirect from commit flushes the queue and in-flight fetch and restarts at the given PC.

## Interface
Parameters:
- IQ_DEPTH, 8: queue entries; power of two, at least 2.
- IQ_ADDR_W, 3: log2(IQ_DEPTH).

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state and forces mem_req_valid=0.
- mem_req_valid  output  1  one-cycle fetch request pulse; the controller always accepts it.
- mem_req_addr  output  `DATA_WIDTH  byte address of requested word.
- mem_resp_valid  input  1  one-cycle pulse; mem_resp_data is valid this cycle.
- mem_resp_data  input  `DATA_WIDTH  fetched instruction word.
- redirect_valid  input  1  flush and restart (mispredict/jalr).
- redirect_pc  input  `DATA_WIDTH  new fetch PC.
- iq_out_valid  output  1  queue non-empty.
- iq_out_inst  output  `DATA_WIDTH  head instruction; feeds decoder inst.
- iq_out_pc  output  `DATA_WIDTH  head PC.
- iq_out_pred_pc  output  `DATA_WIDTH  head predicted next PC.
- iq_out_ready  input  1  consumer pops head when high with iq_out_valid.

## Operation
- Registers:
  - fetch_pc.
  - Circular buffer of {inst, pc, pred_pc}.
  - head/tail pointers (IQ_ADDR_W bits, natural wrap).
  - count (IQ_ADDR_W+1 bits).
  - FSM state.
- FSM states IDLE, WAIT, DROP:
  - IDLE: if count<IQ_DEPTH, pulse mem_req_valid with mem_req_addr=fetch_pc and go to WAIT. Otherwise stay in IDLE.
  - WAIT: on mem_resp_valid, push {mem_resp_data, fetch_pc, pred}, set fetch_pc to pred, and go to IDLE.
  - DROP: on mem_resp_valid, discard the data and go to IDLE.
- Prediction rule:
  - opcode inst[6:0]==7'h6f (JAL): pred = fetch_pc + sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - All other opcodes: pred = fetch_pc + 4.
  - All additions are 32-bit modulo, with no overflow detection.
- Push/pop:
  - Pop occurs when iq_out_valid && iq_out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pop while empty is ignored.
  - Push never occurs while full, because requests are gated on count<IQ_DEPTH.
- Redirect has highest priority:
  - head=tail=0 and count=0; fetch_pc=redirect_pc.
  - Any push or pop in the same cycle is discarded.
  - State transitions: WAIT→DROP (or IDLE if mem_resp_valid is also high this cycle); DROP stays DROP unless mem_resp_valid is high (→IDLE); IDLE stays IDLE.
  - No request is issued in the redirect cycle.
- Empty queue: iq_out_valid=0, and iq_out_inst/pc/pred_pc show the stale head entry.
- Reset:
  - fetch_pc=0, state=IDLE, pointers and count=0, all entries zeroed.
  - mem_req_valid=0, mem_req_addr=0, iq_out_valid=0, iq_out_inst/pc/pred_pc=0.
- rdy_in=0: no register updates. A response arriving while rdy_in=0 is the memory controller's responsibility, since it shares rdy_in.

## Timing
- Request: first mem_req_valid appears in the first cycle after rst_in deasserts.
- At most one request outstanding. Next request is no earlier than the cycle after the response.
- Response to output: data pushed at edge N gives iq_out_valid=1 in cycle N+1. There is no bypass.
- Pop: registered; the head advances at the edge where the handshake occurs.
- Throughput: with a 1-cycle memory response, one instruction every 2 cycles.
- Redirect at edge N: a request for redirect_pc is issued in cycle N+1 if the FSM is in IDLE, otherwise after the pending response is dropped.

## Structure
- Opcode constants (7'h6f JAL, 7'h67 JALR, 7'h63 BRANCH) and `DATA_WIDTH belong in the shared info.v header.
- Sub-module: fetch_queue_fifo, the parameterised circular buffer with push, pop, flush, full/empty and count.
- Top level holds the FSM and predictor.

## Test plan
- Reset, then memory returns ADDI words at 1-cycle latency:
  - requests at addresses 0, 4, 8.
  - iq_out_pc sequence 0, 4, 8 with pred_pc=pc+4.
- JAL at pc 0x10 with imm +0x20 (inst 0x0200006f): pred_pc=0x30 and the next request address is 0x30. JAL with imm -8 at 0x40 gives pred_pc=0x38.
- iq_out_ready=0, continuous responses:
  - count reaches 8 and mem_req_valid stays 0.
  - raising ready for one cycle pops one entry, and a request issues the next cycle.
- Redirect to 0x100 while in WAIT:
  - the in-flight response is dropped and the queue is empty.
  - the next request is for 0x100 and the first iq_out_pc is 0x100.
- Redirect in the same cycle as a push and a pop: count=0, iq_out_valid=0 the next cycle, and no stale entry appears.
- rdy_in low for 3 cycles mid-WAIT: all outputs hold and no request pulses; operation resumes identically afterwards.
